// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: formats stores onto a valid/ready data bus,
// formats returned load data, and stalls the pipeline until the access completes or times out.
module lsu_mem_stage #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [2:0]  Func3M,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      addr_q;
  logic [1:0]       off_q;
  logic [31:0]      wdata_q;
  logic [3:0]       be_q;
  logic             we_q;
  logic [2:0]       func3_q;
  logic [31:0]      data_q;

  logic        access;
  logic        misalign;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] load_c;
  logic [31:0] byte_word;
  logic [15:0] half_sel;
  logic        timeout_hit;

  assign access = MemReadM | MemWriteM;

  always_comb begin
    misalign = 1'b0;
    case (Func3M)
      3'b000, 3'b100: misalign = 1'b0;
      3'b001, 3'b101: misalign = ALUResultM[0];
      3'b010:         misalign = |ALUResultM[1:0];
      default:        misalign = 1'b1;
    endcase
  end

  // Store lanes are replicated so the byte enables alone pick the target bytes.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = WriteDataM;
    if (MemWriteM) begin
      case (Func3M[1:0])
        2'b00: begin
          be_c    = 4'b0001 << ALUResultM[1:0];
          wdata_c = {4{WriteDataM[7:0]}};
        end
        2'b01: begin
          be_c    = 4'b0011 << ALUResultM[1:0];
          wdata_c = {2{WriteDataM[15:0]}};
        end
        default: begin
          be_c    = 4'b1111;
          wdata_c = WriteDataM;
        end
      endcase
    end
  end

  always_comb begin
    byte_word = mem_rdata >> {off_q, 3'b000};
    half_sel  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (func3_q)
      3'b000:  load_c = {{24{byte_word[7]}}, byte_word[7:0]};
      3'b100:  load_c = {24'd0, byte_word[7:0]};
      3'b001:  load_c = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_c = {16'd0, half_sel};
      default: load_c = mem_rdata;
    endcase
  end

  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      func3_q <= '0;
      data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access && !misalign) begin
            addr_q  <= {ALUResultM[31:2], 2'b00};
            off_q   <= ALUResultM[1:0];
            wdata_q <= wdata_c;
            be_q    <= be_c;
            we_q    <= MemWriteM;
            func3_q <= Func3M;
            cnt     <= '0;
            state   <= REQ;
          end
        end
        REQ: begin
          if (mem_ready) begin
            data_q <= we_q ? 32'd0 : load_c;
            state  <= DONE;
          end else if (timeout_hit) begin
            data_q <= 32'd0;
            state  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pulse and stall outputs are gated by reset so an aborted access is silent immediately.
  assign mem_req   = (state == REQ);
  assign mem_we    = mem_req & we_q;
  assign mem_be    = mem_req ? be_q : 4'b0000;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ReadDataM = (state == DONE) ? data_q : 32'd0;
  assign StallM    = reset & (((state == IDLE) & access & ~misalign) | (state == REQ));
  assign MisalignM = reset & (state == IDLE) & access & misalign;
  assign BusErrM   = reset & (state == REQ) & ~mem_ready & timeout_hit;

endmodule
